// File: rtl/cmd_line_assembler.sv
// cmd_line_assembler: collects UART bytes into a CMD_CHARS-wide line buffer,
// handles backspace editing, echoes to the terminal and publishes the line on CR.
// Optional build macro: CMD_UPCASE_EN folds lowercase letters to uppercase in the buffer.
`timescale 1ns/1ps
module cmd_line_assembler #(
  parameter int          CMD_CHARS = 5,
  parameter logic [7:0]  PAD_CHAR  = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [CMD_CHARS*8-1:0] command,
  output logic                   command_valid,
  output logic [7:0]             echo_data,
  output logic                   echo_valid,
  input  logic                   echo_ready,
  output logic [2:0]             char_count,
  output logic                   overflow
);

  typedef enum logic {IDLE, ECHO} state_t;
  state_t state, next_state;

  // char 0 sits at index 0, which is the MSB end of the packed vector
  logic [0:CMD_CHARS-1][7:0] cbuf;

  logic [2:0][7:0] q;          // echo queue
  logic [1:0]      q_len, q_idx;
  logic [2:0][7:0] new_q;
  logic [1:0]      new_len;
  logic            load_echo;

  logic accept, hs, last, full, empty;
  logic is_print, is_bs, is_cr;
  logic [7:0] store_byte;
  logic [1:0] q_nxt_idx;

  assign accept    = rx_valid && rx_ready;
  assign hs        = echo_valid && echo_ready;
  assign last      = (q_idx == q_len - 2'd1);
  assign q_nxt_idx = q_idx + 2'd1;
  assign full      = (char_count == 3'(CMD_CHARS));
  assign empty     = (char_count == 3'd0);
  assign is_print  = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
  assign is_bs     = (rx_data == 8'h08) || (rx_data == 8'h7F);
  assign is_cr     = (rx_data == 8'h0D);

`ifdef CMD_UPCASE_EN
  assign store_byte = ((rx_data >= 8'h61) && (rx_data <= 8'h7A)) ? (rx_data - 8'h20) : rx_data;
`else
  assign store_byte = rx_data;
`endif

  // Classify the incoming byte into the echo sequence it produces
  always_comb begin
    load_echo = 1'b0;
    new_q     = '0;
    new_len   = 2'd0;
    if (is_print) begin
      load_echo = 1'b1;
      new_len   = 2'd1;
      new_q[0]  = full ? 8'h07 : rx_data;  // BEL when the byte is dropped
    end else if (is_bs && !empty) begin
      load_echo = 1'b1;
      new_len   = 2'd3;
      new_q[0]  = 8'h08;
      new_q[1]  = 8'h20;
      new_q[2]  = 8'h08;
    end else if (is_cr) begin
      load_echo = 1'b1;
      new_len   = 2'd2;
      new_q[0]  = 8'h0D;
      new_q[1]  = 8'h0A;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and handshake outputs; echo_valid depends only on state
  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    echo_valid = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (accept && load_echo) next_state = ECHO;
      end
      ECHO: begin
        echo_valid = 1'b1;
        if (hs && last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Line buffer, counters, command publish and echo queue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cbuf          <= {CMD_CHARS{PAD_CHAR}};
      char_count    <= 3'd0;
      overflow      <= 1'b0;
      command       <= '0;
      command_valid <= 1'b0;
      q             <= '0;
      q_len         <= 2'd0;
      q_idx         <= 2'd0;
      echo_data     <= 8'h00;
    end else begin
      command_valid <= 1'b0;
      if (accept) begin
        if (is_print) begin
          if (!full) begin
            for (int i = 0; i < CMD_CHARS; i++)
              if (3'(i) == char_count) cbuf[i] <= store_byte;
            char_count <= char_count + 3'd1;
          end else begin
            overflow <= 1'b1;
          end
        end else if (is_bs && !empty) begin
          for (int i = 0; i < CMD_CHARS; i++)
            if (3'(i) == char_count - 3'd1) cbuf[i] <= PAD_CHAR;
          char_count <= char_count - 3'd1;
        end else if (is_cr) begin
          // any CR ends the line, so the overflow flag is cleared even on an empty line
          overflow <= 1'b0;
          if (!empty) begin
            command       <= cbuf;
            command_valid <= 1'b1;
            cbuf          <= {CMD_CHARS{PAD_CHAR}};
            char_count    <= 3'd0;
          end
        end
      end
      if (accept && load_echo) begin
        q         <= new_q;
        q_len     <= new_len;
        q_idx     <= 2'd0;
        echo_data <= new_q[0];
      end else if (hs && !last) begin
        q_idx     <= q_nxt_idx;
        echo_data <= q[q_nxt_idx];
      end
    end
  end

endmodule
